// File: rtl/expr_result_sink.sv
// Result sink: folds accepted 90-bit result beats into a 32-bit CRC-style signature and counts beats per run.
// Optional fixed-field checking is enabled with the macro EXPR_SINK_FIELD_CHECK_EN.
module expr_result_sink #(
   parameter int          COUNT_W = 16,
   parameter logic [31:0] SEED    = 32'hFFFFFFFF,
   parameter logic [31:0] POLY    = 32'h04C11DB7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [89:0]        in_y,
   input  logic               in_last,
   output logic [31:0]        sig_out,
   output logic               sig_valid,
   input  logic               sig_ack,
   output logic [COUNT_W-1:0] count,
   output logic               chk_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic               in_ready_r;
   logic               in_ready_s;
   logic               sig_valid_r;
   logic               sig_valid_s;
   logic [31:0]        sig_r;
   logic [COUNT_W-1:0] count_r;
   logic               accept_s;
   logic               ack_s;

   localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
   localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   // Signature step: shift left, feed back POLY when the MSB falls out, then mix in the folded beat.
   function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic [89:0] y);
      logic [31:0] fold;
      fold = y[31:0] ^ y[63:32] ^ {6'b000000, y[89:64]};
      return {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h00000000) ^ fold;
   endfunction

   assign accept_s = in_valid & in_ready_r;
   assign ack_s    = (state_r == DONE) & sig_ack;

   // Next-state decode; handshake outputs are decoded from the next state so they can be registered.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = in_last ? DONE : ACCUM;
            end else begin
               state_s = IDLE;
            end
         end
         ACCUM: begin
            if (accept_s && in_last) begin
               state_s = DONE;
            end else begin
               state_s = ACCUM;
            end
         end
         DONE: begin
            if (sig_ack) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      in_ready_s  = (state_s != DONE);
      sig_valid_s = (state_s == DONE);
   end

   // State and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         sig_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= in_ready_s;
         sig_valid_r <= sig_valid_s;
      end
   end

   // Signature and saturating beat counter; frozen in DONE until acknowledged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_r   <= SEED;
         count_r <= {COUNT_W{1'b0}};
      end else if (ack_s) begin
         sig_r   <= SEED;
         count_r <= {COUNT_W{1'b0}};
      end else if (accept_s) begin
         sig_r   <= sig_step(sig_r, in_y);
         count_r <= (count_r == COUNT_MAX) ? count_r : count_r + COUNT_ONE;
      end else begin
         sig_r   <= sig_r;
         count_r <= count_r;
      end
   end

`ifdef EXPR_SINK_FIELD_CHECK_EN
   logic chk_err_r;

   // True when any of the constant header fields in the beat deviates from its expected value.
   function automatic logic field_bad(input logic [89:0] y);
      return (y[89:86] != 4'd8) || (y[55:51] != 5'd31) ||
             (y[40:36] != 5'd4) || (y[25:21] != 5'd30);
   endfunction

   // Sticky mismatch flag, cleared together with the signature on acknowledge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_err_r <= 1'b0;
      end else if (ack_s) begin
         chk_err_r <= 1'b0;
      end else if (accept_s && field_bad(in_y)) begin
         chk_err_r <= 1'b1;
      end else begin
         chk_err_r <= chk_err_r;
      end
   end

   assign chk_err = chk_err_r;
`else
   assign chk_err = 1'b0;
`endif

   assign in_ready  = in_ready_r;
   assign sig_valid = sig_valid_r;
   assign sig_out   = sig_r;
   assign count     = count_r;

endmodule

// File: tb/tb_expr_result_sink.sv
// Self-checking bench for expr_result_sink: directed scenarios plus randomized runs against a behavioural model.
module tb_expr_result_sink;

   localparam int          CW   = 4;
   localparam logic [31:0] SEED = 32'hFFFFFFFF;
   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [89:0]   in_y = '0;
   logic          in_last = 1'b0;
   logic [31:0]   sig_out;
   logic          sig_valid;
   logic          sig_ack = 1'b0;
   logic [CW-1:0] count;
   logic          chk_err;

   int errors = 0;
   int checks = 0;

   // Reference model state: one run in progress or one finished signature waiting for ack.
   logic [31:0] m_sig   = SEED;
   int          m_count = 0;
   bit          m_chk   = 1'b0;
   bit          m_done  = 1'b0;

   expr_result_sink #(.COUNT_W(CW), .SEED(SEED), .POLY(POLY)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_y(in_y), .in_last(in_last), .sig_out(sig_out), .sig_valid(sig_valid),
      .sig_ack(sig_ack), .count(count), .chk_err(chk_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Signature update written as polynomial arithmetic over GF(2): multiply by x, reduce, add the fold.
   function automatic logic [31:0] model_next(input logic [31:0] s, input logic [89:0] y);
      logic [32:0] prod;
      logic [31:0] fold;
      fold = y[31:0] ^ y[63:32] ^ 32'(y[89:64]);
      prod = 33'(s) * 33'd2;
      if (prod[32]) prod = prod ^ {1'b1, POLY};
      return prod[31:0] ^ fold;
   endfunction

   function automatic bit model_field_bad(input logic [89:0] y);
      return !(y[89:86] == 4'd8 && y[55:51] == 5'd31 && y[40:36] == 5'd4 && y[25:21] == 5'd30);
   endfunction

   task automatic model_reset();
      m_sig = SEED; m_count = 0; m_chk = 1'b0; m_done = 1'b0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".in_ready"},  32'(in_ready),  32'(!m_done));
      check({tag, ".sig_valid"}, 32'(sig_valid), 32'(m_done));
      check({tag, ".sig_out"},   sig_out,        m_sig);
      check({tag, ".count"},     32'(count),     32'(m_count));
      check({tag, ".chk_err"},   32'(chk_err),   32'(m_chk));
   endtask

   // Drive one clock cycle from a falling edge to the next falling edge, updating the model at the rising edge.
   task automatic cycle(input bit v, input logic [89:0] y, input bit l, input bit a);
      in_valid = v; in_y = y; in_last = l; sig_ack = a;
      @(posedge clk);
      if (m_done) begin
         if (a) model_reset();
      end else if (v) begin
         m_sig = model_next(m_sig, y);
         if (m_count < (1 << CW) - 1) m_count++;
`ifdef EXPR_SINK_FIELD_CHECK_EN
         if (model_field_bad(y)) m_chk = 1'b1;
`endif
         if (l) m_done = 1'b1;
      end
      @(negedge clk);
   endtask

   function automatic logic [89:0] rand_y();
      return {$urandom(), $urandom(), $urandom()};
   endfunction

   logic [89:0] good_y;
   logic [89:0] bad_y;

   initial begin
      good_y = '0;
      good_y[89:86] = 4'd8; good_y[55:51] = 5'd31; good_y[40:36] = 5'd4; good_y[25:21] = 5'd30;
      bad_y = good_y;
      bad_y[55:51] = 5'd30;

      // Reset state
      repeat (2) @(negedge clk);
      model_reset();
      check_all("reset");
      rst_n = 1'b1;

      // Single zero beat with last
      cycle(1'b1, 90'd0, 1'b1, 1'b0);
      check_all("single");
      check("single.sig_const", sig_out, 32'hFB3EE249);
      check("single.count_const", 32'(count), 32'd1);

      // Upstream holds a beat during DONE: nothing accepted
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, rand_y(), 1'b0, 1'b0);
         check_all("hold");
      end
      cycle(1'b0, 90'd0, 1'b0, 1'b1);
      check_all("ack");
      check("ack.sig_seed", sig_out, 32'hFFFFFFFF);

      // Ack outside DONE is ignored
      cycle(1'b0, 90'd0, 1'b0, 1'b1);
      check_all("stray_ack");

      // Counter saturation: 20 beats into a 4-bit counter
      for (int i = 0; i < 20; i++) cycle(1'b1, rand_y(), (i == 19), 1'b0);
      check_all("sat");
      check("sat.count_const", 32'(count), 32'd15);
      cycle(1'b0, 90'd0, 1'b0, 1'b1);
      check_all("sat_ack");

      // Fixed-field check
      cycle(1'b1, good_y, 1'b0, 1'b0);
      check_all("field_good");
      cycle(1'b1, bad_y, 1'b1, 1'b0);
      check_all("field_bad");
`ifdef EXPR_SINK_FIELD_CHECK_EN
      check("field_bad.chk_const", 32'(chk_err), 32'd1);
`else
      check("field_bad.chk_const", 32'(chk_err), 32'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 90'd0, 1'b0, 1'b0);
         check_all("field_hold");
      end
      cycle(1'b0, 90'd0, 1'b0, 1'b1);
      check_all("field_ack");

      // Reset mid-run is asynchronous and discards the partial run
      for (int i = 0; i < 3; i++) cycle(1'b1, rand_y(), 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 90'd0, 1'b1, 1'b0);
      check_all("post_rst");
      check("post_rst.sig_const", sig_out, 32'hFB3EE249);
      cycle(1'b0, 90'd0, 1'b0, 1'b1);

      // Randomized runs with gaps, unqualified in_last, and delayed acks
      for (int run = 0; run < 40; run++) begin
         int len;
         len = $urandom_range(1, 8);
         for (int b = 0; b < len; b++) begin
            while ($urandom_range(0, 2) == 0) begin
               cycle(1'b0, rand_y(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
               check_all("rnd_gap");
            end
            cycle(1'b1, ($urandom_range(0, 3) == 0) ? good_y : rand_y(), (b == len - 1), 1'b0);
            check_all("rnd_beat");
         end
         for (int w = $urandom_range(0, 3); w > 0; w--) begin
            cycle(1'($urandom_range(0, 1)), rand_y(), 1'($urandom_range(0, 1)), 1'b0);
            check_all("rnd_wait");
         end
         cycle(1'($urandom_range(0, 1)), rand_y(), 1'b0, 1'b1);
         check_all("rnd_ack");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
